// File: rtl/ramb16_s2_march_bist.sv
// March C- self-test controller for one port of an 8192 x 2 block RAM.
// Issues one RAM op per cycle, checks each read one cycle later, and latches the first mismatch.
module ramb16_s2_march_bist #(
   parameter int                ADDR_W    = 13,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 13'h1FFF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic              FAIL,
   output logic [ADDR_W-1:0] FAIL_ADDR,
   output logic [2:0]        FAIL_ELEM,
   output logic [1:0]        FAIL_EXP,
   output logic [1:0]        FAIL_GOT,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [1:0]        RAM_DI,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic              RAM_SSR,
   input  logic [1:0]        RAM_DO
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t            state, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              phase_q, phase_d;
   logic              rd_pend;
   logic [1:0]        exp_q;
   logic [ADDR_W-1:0] pend_addr;
   logic [2:0]        pend_elem;

   logic              mism, last_in_elem, two_op;
   logic              busy_d, done_d, pass_d, fail_d, en_d, we_d;
   logic [ADDR_W-1:0] addr_d, fail_addr_d;
   logic [2:0]        fail_elem_d;
   logic [1:0]        di_d, fail_exp_d, fail_got_d;

   // E3 and E4 walk the array downwards; everything else walks up.
   function automatic logic is_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   assign RAM_SSR = 1'b0;

   always_comb begin
      state_d     = state;
      elem_d      = elem_q;
      phase_d     = phase_q;
      addr_d      = RAM_ADDR;
      di_d        = RAM_DI;
      en_d        = RAM_EN;
      we_d        = RAM_WE;
      pass_d      = PASS;
      fail_d      = FAIL;
      fail_addr_d = FAIL_ADDR;
      fail_elem_d = FAIL_ELEM;
      fail_exp_d  = FAIL_EXP;
      fail_got_d  = FAIL_GOT;

      mism         = rd_pend && (RAM_DO != exp_q) && ((state == S_RUN) || (state == S_FLUSH));
      last_in_elem = is_down(elem_q) ? (RAM_ADDR == '0) : (RAM_ADDR == LAST_ADDR);
      two_op       = (elem_q != 3'd0) && (elem_q != 3'd5);

      case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d     = S_RUN;
               elem_d      = 3'd0;
               phase_d     = 1'b0;
               addr_d      = '0;
               di_d        = 2'b00;
               en_d        = 1'b1;
               we_d        = 1'b1;
               pass_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 3'd0;
               fail_exp_d  = 2'b00;
               fail_got_d  = 2'b00;
            end
         end
         S_RUN: begin
            if ((elem_q == 3'd5) && last_in_elem) begin
               state_d = S_FLUSH;
               en_d    = 1'b0;
               we_d    = 1'b0;
               di_d    = 2'b00;
               addr_d  = '0;
            end else begin
               if (two_op && !phase_q) begin
                  phase_d = 1'b1;
               end else if (last_in_elem) begin
                  elem_d  = elem_q + 3'd1;
                  phase_d = 1'b0;
                  addr_d  = is_down(elem_d) ? LAST_ADDR : '0;
               end else begin
                  phase_d = 1'b0;
                  addr_d  = is_down(elem_q) ? RAM_ADDR - ADDR_W'(1) : RAM_ADDR + ADDR_W'(1);
               end
               // Odd elements write the "1" background, even ones write "0".
               en_d = 1'b1;
               we_d = (elem_d == 3'd0) || phase_d;
               di_d = we_d ? {2{elem_d[0]}} : 2'b00;
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
            pass_d  = 1'b1;
            fail_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (mism) begin
         state_d     = S_DONE;
         en_d        = 1'b0;
         we_d        = 1'b0;
         di_d        = 2'b00;
         addr_d      = '0;
         pass_d      = 1'b0;
         fail_d      = 1'b1;
         fail_addr_d = pend_addr;
         fail_elem_d = pend_elem;
         fail_exp_d  = exp_q;
         fail_got_d  = RAM_DO;
      end

      busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         elem_q    <= 3'd0;
         phase_q   <= 1'b0;
         rd_pend   <= 1'b0;
         exp_q     <= 2'b00;
         pend_addr <= '0;
         pend_elem <= 3'd0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         FAIL      <= 1'b0;
         FAIL_ADDR <= '0;
         FAIL_ELEM <= 3'd0;
         FAIL_EXP  <= 2'b00;
         FAIL_GOT  <= 2'b00;
         RAM_ADDR  <= '0;
         RAM_DI    <= 2'b00;
         RAM_EN    <= 1'b0;
         RAM_WE    <= 1'b0;
      end else begin
         elem_q    <= elem_d;
         phase_q   <= phase_d;
         // Reads expect the complement of what their own element writes.
         rd_pend   <= (state == S_RUN) && RAM_EN && !RAM_WE;
         exp_q     <= elem_q[0] ? 2'b00 : 2'b11;
         pend_addr <= RAM_ADDR;
         pend_elem <= elem_q;
         BUSY      <= busy_d;
         DONE      <= done_d;
         PASS      <= pass_d;
         FAIL      <= fail_d;
         FAIL_ADDR <= fail_addr_d;
         FAIL_ELEM <= fail_elem_d;
         FAIL_EXP  <= fail_exp_d;
         FAIL_GOT  <= fail_got_d;
         RAM_ADDR  <= addr_d;
         RAM_DI    <= di_d;
         RAM_EN    <= en_d;
         RAM_WE    <= we_d;
      end
   end

endmodule

// File: tb/tb_ramb16_s2_march_bist.sv
// Bench for ramb16_s2_march_bist: RAM model with a stuck-bit fault, march reference model,
// spec-derived vector table, and hand-written reset / restart / START-hold sequences.
module tb_ramb16_s2_march_bist;
   localparam int N     = 16;
   localparam int TOTAL = 10 * N;

   logic        CLK = 1'b0;
   logic        RST, START;
   logic        BUSY, DONE, PASS, FAIL;
   logic [12:0] FAIL_ADDR;
   logic [2:0]  FAIL_ELEM;
   logic [1:0]  FAIL_EXP, FAIL_GOT;
   logic [12:0] RAM_ADDR;
   logic [1:0]  RAM_DI;
   logic [1:0]  RAM_DO = 2'b00;
   logic        RAM_EN, RAM_WE, RAM_SSR;

   always #5 CLK = ~CLK;

   ramb16_s2_march_bist #(.ADDR_W(13), .LAST_ADDR(13'd15)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL(FAIL),
      .FAIL_ADDR(FAIL_ADDR), .FAIL_ELEM(FAIL_ELEM), .FAIL_EXP(FAIL_EXP), .FAIL_GOT(FAIL_GOT),
      .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR),
      .RAM_DO(RAM_DO)
   );

   typedef struct { bit on; int addr; int bitn; bit val; } fault_t;
   typedef struct { bit we; int addr; logic [1:0] d; int elem; } op_t;
   typedef struct {
      string name; fault_t f; bit pass; int elem; int addr;
      logic [1:0] exp; logic [1:0] got; int busy; int nwr; int nrd;
   } vec_t;

   fault_t      cur_f;
   logic [1:0]  mem [0:8191];
   op_t         ops[$];
   int          checks = 0;
   int          failures = 0;
   logic        log_we [0:255];
   logic [12:0] log_addr [0:255];
   logic [1:0]  log_di [0:255];

   function automatic logic [1:0] apply_fault(input logic [1:0] v, input int a, input fault_t f);
      logic [1:0] r;
      r = v;
      if (f.on && a == f.addr) r[f.bitn] = f.val;
      return r;
   endfunction

   // Registered-output RAM; the fault corrupts the value seen on reads.
   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_DI;
         else        RAM_DO <= apply_fault(mem[RAM_ADDR], int'(RAM_ADDR), cur_f);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Full March C- op list, straight from the element table.
   function automatic void build_ops();
      int a;
      ops.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = (e == 3 || e == 4) ? N - 1 - i : i;
            if (e != 0) ops.push_back('{1'b0, a, (e == 2 || e == 4) ? 2'b11 : 2'b00, e});
            if (e != 5) ops.push_back('{1'b1, a, (e == 1 || e == 3) ? 2'b11 : 2'b00, e});
         end
      end
   endfunction

   // Index of the first failing read op, or -1 when the march passes.
   function automatic int predict(input fault_t f, output op_t fop, output logic [1:0] got);
      logic [1:0] m [0:N-1];
      logic [1:0] v;
      for (int k = 0; k < ops.size(); k++) begin
         if (ops[k].we) m[ops[k].addr] = ops[k].d;
         else begin
            v = apply_fault(m[ops[k].addr], ops[k].addr, f);
            if (v !== ops[k].d) begin
               fop = ops[k];
               got = v;
               return k;
            end
         end
      end
      fop = ops[0];
      got = 2'b00;
      return -1;
   endfunction

   task automatic run_march(input string nm, input fault_t f, input bit hold,
                            output int busy, output int nwr, output int nrd);
      int p, n_exp, idx, ewr, erd;
      op_t fop;
      logic [1:0] got;
      bit seen_done;
      cur_f = f;
      p = predict(f, fop, got);
      n_exp = (p < 0) ? TOTAL : ((p + 2 < TOTAL) ? p + 2 : TOTAL);
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); if (!hold) START = 1'b0;
      chk({nm, " busy_rise"}, {DONE, BUSY}, 2'b01);
      chk({nm, " status_cleared"}, {PASS, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_EXP, FAIL_GOT}, 0);
      busy = 0; nwr = 0; nrd = 0; idx = 0; seen_done = 0;
      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
         if (cyc > 0) @(negedge CLK);
         if (DONE) begin
            seen_done = 1;
            START = 1'b0;
         end else begin
            if (BUSY) busy++;
            if (RAM_EN) begin
               if (idx < 256) begin
                  log_we[idx] = RAM_WE; log_addr[idx] = RAM_ADDR; log_di[idx] = RAM_DI;
               end
               if (idx < n_exp)
                  chk($sformatf("%s op%0d", nm, idx), {RAM_WE, RAM_ADDR, RAM_WE ? RAM_DI : 2'b00},
                      {ops[idx].we, 13'(ops[idx].addr), ops[idx].we ? ops[idx].d : 2'b00});
               if (RAM_WE) nwr++; else nrd++;
               idx++;
            end
         end
      end
      START = 1'b0;
      chk({nm, " done_seen"}, 32'(seen_done), 1);
      chk({nm, " ops_issued"}, idx, n_exp);
      chk({nm, " busy_cycles"}, busy, (p < 0) ? TOTAL + 1 : p + 2);
      ewr = 0; erd = 0;
      for (int k = 0; k < n_exp; k++) if (ops[k].we) ewr++; else erd++;
      chk({nm, " writes"}, nwr, ewr);
      chk({nm, " reads"}, nrd, erd);
      chk({nm, " pass_fail"}, {PASS, FAIL}, (p < 0) ? 2'b10 : 2'b01);
      if (p >= 0)
         chk({nm, " fail_fields"}, {FAIL_ADDR, FAIL_ELEM, FAIL_EXP, FAIL_GOT},
             {13'(fop.addr), 3'(fop.elem), fop.d, got});
      repeat (2) @(negedge CLK);
      chk({nm, " done_hold"}, {DONE, BUSY, RAM_EN, RAM_SSR}, 4'b1000);
   endtask

   vec_t   vecs [0:3];
   fault_t nof, rf;
   int     b, w, r;

   initial begin
      RST = 1'b1; START = 1'b0;
      nof = '{1'b0, 0, 0, 1'b0};
      cur_f = nof;
      for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom_range(0, 3));
      vecs[0] = '{"nofault",    '{1'b0, 0, 0, 1'b0}, 1'b1, 0, 0,  2'b00, 2'b00, 161, 80, 80};
      vecs[1] = '{"a5_b0_sa1",  '{1'b1, 5, 0, 1'b1}, 1'b0, 1, 5,  2'b00, 2'b01, 28,  22, 6};
      vecs[2] = '{"a15_b1_sa0", '{1'b1, 15, 1, 1'b0}, 1'b0, 2, 15, 2'b11, 2'b01, 80,  48, 32};
      vecs[3] = '{"nofault_re", '{1'b0, 0, 0, 1'b0}, 1'b1, 0, 0,  2'b00, 2'b00, 161, 80, 80};
      build_ops();
      repeat (3) @(negedge CLK);
      chk("reset_status", {BUSY, DONE, PASS, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_EXP, FAIL_GOT}, 0);
      chk("reset_ram", {RAM_ADDR, RAM_DI, RAM_EN, RAM_WE, RAM_SSR}, 0);
      RST = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_march(vecs[i].name, vecs[i].f, 1'b0, b, w, r);
         chk({vecs[i].name, " tbl_busy"}, b, vecs[i].busy);
         chk({vecs[i].name, " tbl_writes"}, w, vecs[i].nwr);
         chk({vecs[i].name, " tbl_reads"}, r, vecs[i].nrd);
         chk({vecs[i].name, " tbl_pass"}, {PASS, FAIL}, {vecs[i].pass, !vecs[i].pass});
         if (!vecs[i].pass)
            chk({vecs[i].name, " tbl_fail"}, {FAIL_ADDR, FAIL_ELEM, FAIL_EXP, FAIL_GOT},
                {13'(vecs[i].addr), 3'(vecs[i].elem), vecs[i].exp, vecs[i].got});
         if (i == 0) begin
            chk("e3_first_op", {log_we[80], log_addr[80]}, {1'b0, 13'd15});
            chk("e3_second_op", {log_we[81], log_addr[81], log_di[81]}, {1'b1, 13'd15, 2'b11});
            chk("e4_last_op", {log_we[143], log_addr[143], log_di[143]}, {1'b1, 13'd0, 2'b00});
         end
      end

      // Reset in the middle of a run, then a clean full run.
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      repeat (49) @(negedge CLK);
      chk("midrun_busy", {BUSY, RAM_EN}, 2'b11);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrun_rst_status", {BUSY, DONE, PASS, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_EXP, FAIL_GOT}, 0);
      chk("midrun_rst_ram", {RAM_ADDR, RAM_DI, RAM_EN, RAM_WE, RAM_SSR}, 0);
      RST = 1'b0;
      run_march("after_rst", nof, 1'b0, b, w, r);

      // START held high for the whole run must not restart or disturb it.
      run_march("start_hold", nof, 1'b1, b, w, r);
      chk("start_hold_pass", {PASS, b}, {1'b1, 32'(TOTAL + 1)});

      for (int k = 0; k < 6; k++) begin
         rf.on   = 1'b1;
         rf.addr = $urandom_range(0, N - 1);
         rf.bitn = $urandom_range(0, 1);
         rf.val  = 1'($urandom_range(0, 1));
         run_march($sformatf("rand%0d_a%0d_b%0d_v%0d", k, rf.addr, rf.bitn, rf.val), rf, 1'b0, b, w, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ramb16_s2_march_bist.md
# ramb16_s2_march_bist

Built-in self-test controller that drives one port of an 8192 x 2 dual-port block RAM. It runs a March C- sequence over the array, compares every read against the expected background, and reports pass/fail plus the first failing location. It sits between system control and the RAM port (ADDR/DI/EN/WE/SSR/DO) and owns that port while BUSY is high.

## Interface
Parameters:
- ADDR_W, 13, RAM address width.
- LAST_ADDR, 13'h1FFF, highest address tested; N = LAST_ADDR+1. Set small for fast simulation.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  begin test; sampled in IDLE or DONE only.
- BUSY  out  1  high while a test is in progress.
- DONE  out  1  level; high in DONE state.
- PASS  out  1  valid when DONE=1; 1 = no mismatch.
- FAIL  out  1  valid when DONE=1; 1 = mismatch found.
- FAIL_ADDR  out  ADDR_W  address of the first mismatch.
- FAIL_ELEM  out  3  march element (0..5) of the first mismatch.
- FAIL_EXP  out  2  expected data at the first mismatch.
- FAIL_GOT  out  2  RAM_DO value at the first mismatch.
- RAM_ADDR  out  ADDR_W  RAM port address.
- RAM_DI  out  2  RAM write data.
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM write enable.
- RAM_SSR  out  1  RAM output reset; constant 0.
- RAM_DO  in  2  RAM registered read data. Valid in the cycle after the read edge.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- Background values: "0" = 2'b00, "1" = 2'b11.
- Elements:
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Op sequencing:
  - One op per RUN cycle. RAM_EN=1 on every RUN cycle.
  - Read ops drive RAM_WE=0. Write ops drive RAM_WE=1 with RAM_DI set to the background.
  - A read followed by a write at the same address is issued in consecutive cycles.
- Addressing:
  - "up" elements count 0 to LAST_ADDR; "down" elements count LAST_ADDR to 0.
  - No wrap-around. At the element's last address, the next op starts the following element at its first address.
- Compare pipeline:
  - A read issued in cycle t registers rd_pend=1, exp, addr and elem at edge t.
  - During cycle t+1, RAM_DO is compared against exp. A mismatch is registered at edge t+1.
- On the first mismatch:
  - Capture FAIL_ADDR, FAIL_ELEM, FAIL_EXP and FAIL_GOT.
  - Go to DONE with FAIL=1, PASS=0.
  - The op driven in the mismatch cycle still executes. No further ops are issued.
- After the last E5 read, the FSM enters FLUSH for one cycle (RAM_EN=0) to compare that read.
- If FLUSH ends with no mismatch: DONE with PASS=1, FAIL=0.
- START handling:
  - START while BUSY is ignored.
  - START in DONE restarts the test. PASS, FAIL and the FAIL_* fields clear at the same edge that enters RUN.
- RST at any point, including mid-run:
  - Next edge forces IDLE.
  - Every output returns to its reset value.
  - RAM contents are left undefined.

## Timing
- Reset values: all outputs 0, i.e.
  - BUSY, DONE, PASS, FAIL = 0
  - FAIL_* = 0
  - RAM_ADDR = 0, RAM_DI = 0
  - RAM_EN = 0, RAM_WE = 0, RAM_SSR = 0
- START sampled at edge k → RUN from edge k. BUSY=1, RAM_EN=1 and the E0 write to address 0 all appear in cycle k+1.
- RUN lasts exactly 10N cycles if fault-free: E0 = N, E1–E4 = 2N each, E5 = N. That is 5N writes and 5N reads.
- FLUSH is 1 cycle with BUSY=1. DONE rises 10N+1 cycles after BUSY rises, and BUSY falls in the same cycle.
- Fault-free default (N=8192): 81920 RUN cycles + 1 FLUSH cycle.
- On mismatch: DONE rises and BUSY falls 1 cycle after the failing read's result cycle.
- Outputs are registered. RAM_DO is the only input with a combinational path, and it feeds only the compare register.

## Test plan
- Fault-free RAM model, LAST_ADDR=15, one-cycle START → BUSY high 161 cycles, 80 cycles with RAM_WE=1, 80 reads. Then DONE=1, PASS=1, FAIL=0.
- Model forces RAM_DO[0]=1 on reads of address 5 → FAIL=1, PASS=0, FAIL_ADDR=5, FAIL_ELEM=1, FAIL_EXP=2'b00, FAIL_GOT=2'b01. The RAM_WE=1 cycle count before DONE is 16+5+1=22.
- Model forces bit1 stuck-at-0 at address 15 → FAIL_ELEM=2, FAIL_ADDR=15, FAIL_EXP=2'b11, FAIL_GOT=2'b01.
- Address order, LAST_ADDR=15:
  - First E3 op (cycle 1+16+32+32 after BUSY rise) is a read of address 15 with RAM_WE=0.
  - Next cycle is a write of 2'b11 to address 15.
  - Last E4 op is a write of 2'b00 to address 0.
- Assert RST for one cycle at RUN cycle 50 → next cycle all outputs 0 with RAM_EN=0. START again → full pass with PASS=1.
- START held high through BUSY → no restart and no glitch. START pulsed in DONE after a failing run → PASS, FAIL and FAIL_* read 0 from the next cycle, and BUSY=1.
